// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the framed serial receiver.
// Frame layout: one start bit, WIDTH data bits (LSB first), one stop bit.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width of a counter that can hold the values 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shifter: new bits enter at the MSB and move toward
// bit 0, so the first bit shifted in finishes at q[0].
module sipo_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  // Shift register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {WIDTH{1'b0}};
    end else if (shift_en) begin
      q <= {serial_in, q[WIDTH-1:1]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller: sequences sipo_shift through start/data/stop bits and
// hands completed words to a one-deep holding register with valid/ready.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             serial_in,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  rx_state_t        state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shift_q_s;
  logic             shift_en_s;
  logic             stop_strobe_s;
  logic             good_s;
  logic             bad_s;
  logic             load_s;
  logic             drop_s;
  logic             accept_s;

  assign shift_en_s    = bit_en & (state_r == ST_SHIFT);
  assign stop_strobe_s = bit_en & (state_r == ST_STOP);
  assign good_s        = stop_strobe_s & (serial_in == STOP_BIT);
  assign bad_s         = stop_strobe_s & (serial_in != STOP_BIT);
  // A full holding register still takes a new word if the consumer drains it this cycle.
  assign load_s        = good_s & (~data_valid | out_ready);
  assign drop_s        = good_s & data_valid & ~out_ready;
  assign accept_s      = data_valid & out_ready;

  sipo_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en_s),
    .serial_in(serial_in),
    .q        (shift_q_s)
  );

  // Frame sequencer with bit counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      busy    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bit_en && (serial_in == START_BIT)) begin
            state_r <= ST_SHIFT;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (bit_en) begin
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              cnt_r <= cnt_r;
            end
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_STOP;
            end else begin
              state_r <= ST_SHIFT;
            end
          end else begin
            state_r <= ST_SHIFT;
          end
          busy <= 1'b1;
        end
        ST_STOP: begin
          if (bit_en) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= ST_STOP;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Holding register and its valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= {WIDTH{1'b0}};
      data_valid <= 1'b0;
    end else if (load_s) begin
      data_out   <= shift_q_s;
      data_valid <= 1'b1;
    end else if (accept_s) begin
      data_out   <= data_out;
      data_valid <= 1'b0;
    end else begin
      data_out   <= data_out;
      data_valid <= data_valid;
    end
  end

  // Error reporting: frame_err pulses, overrun is sticky with clear priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_s;
      if (clr_ovr) begin
        overrun <= 1'b0;
      end else if (drop_s) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule
